seq_serializer: RTL
===================

Name: seq_serializer

Overview:
Parallel-to-serial front end for the bit-serial sequence detectors in the FSM library. It accepts WIDTH-bit words over a valid/ready handshake and holds one word in a buffer while the previous word shifts out. It drives one bit per clock on x_out, which connects directly to a detector's x input. Between words it drives a fixed idle level, so the downstream detector, which samples every clock, sees a defined stream.

Parameters:
WIDTH, 8, bits per word; legal range 2..32.
MSB_FIRST, 1, 1 = shift out din[WIDTH-1] first; 0 = shift out din[0] first.
IDLE_BIT, 1, level driven on x_out when no word is shifting.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
din  input  WIDTH  parallel word to serialize.
din_valid  input  1  din is valid this cycle.
din_ready  output  1  block can accept a word this cycle.
x_out  output  1  serial bit stream to the downstream detector.
x_valid  output  1  x_out carries a data bit, not idle.
frame_done  output  1  high during the last bit of each word.
busy  output  1  a word is shifting or held.

Behaviour:
- Storage:
  - Holding buffer hold[WIDTH-1:0] with flag hold_full.
  - Shift register sh[WIDTH-1:0].
  - Bit counter cnt, width clog2(WIDTH).
  - FSM state: IDLE or SHIFT.
- Reset (rst_n low at an edge):
  - state=IDLE, hold_full=0, sh=0, cnt=0.
  - Outputs after that edge: din_ready=1, x_out=IDLE_BIT, x_valid=0, frame_done=0, busy=0.
  - Reset mid-frame discards both the shifting word and the held word; no partial bits follow.
- Handshake:
  - din_ready = !hold_full (combinational from the registered flag).
  - Transfer occurs on an edge where din_valid && din_ready; hold<=din, hold_full<=1.
  - din is not required to stay stable after the transfer edge.
  - din_valid while din_ready=0 is ignored; the source holds the word until ready.
- Outputs (combinational from registers):
  - x_valid = (state==SHIFT).
  - x_out = SHIFT ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : IDLE_BIT.
  - frame_done = (state==SHIFT && cnt==WIDTH-1).
  - busy = (state==SHIFT) || hold_full.
- IDLE state:
  - If hold_full=1 at an edge: sh<=hold, cnt<=0, hold_full<=0, state<=SHIFT.
  - Else remain in IDLE.
- SHIFT state, cnt<WIDTH-1: sh shifts one position toward the output end (zero-fill); cnt<=cnt+1.
- SHIFT state, cnt==WIDTH-1:
  - If hold_full=1: reload sh<=hold, cnt<=0, hold_full<=0, stay in SHIFT. There is no idle gap between words.
  - Else: state<=IDLE.
- No same-edge accept and buffer transfer: din_ready is 0 whenever hold_full=1. The buffer frees one cycle after the transfer. Because WIDTH>=2, a continuously valid source still streams gap-free.
- Latency: the word accepted at edge N (block idle) shows its first bit on x_out in the cycle after edge N+1. It occupies exactly WIDTH consecutive x_valid cycles.
- cnt never exceeds WIDTH-1. The sh value in IDLE is don't-care but must not reach x_out.

Test Plan:
- Reset check: rst_n low for 2 edges with din_valid=1 -> after release din_ready=1, x_valid=0, x_out=1, busy=0, and nothing accepted during reset.
- Single word: WIDTH=8, MSB_FIRST=1, din=8'h66 for one cycle -> x_out = 0,1,1,0,0,1,1,0 on 8 consecutive x_valid cycles. frame_done is high only on the 8th. Then x_out=1 and x_valid=0.
- Back-to-back: din_valid held high with 8'hA5 then 8'h3C -> 16 contiguous x_valid cycles: 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0. frame_done on bits 8 and 16. din_ready low while the buffer is full.
- Backpressure: present 3 words with din_valid constantly high -> the third is accepted only after the second moves to sh. All 24 bits appear in order, with no loss or duplication.
- LSB-first: MSB_FIRST=0, din=8'h06 -> x_out = 0,1,1,0,0,0,0,0.
- Reset mid-frame: assert rst_n low after 3 bits of 8'hFF with 8'h0F held -> next cycle x_valid=0, x_out=1, din_ready=1, busy=0. Neither word resumes after release.

Source files
------------

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the bit-serial sequence detectors.
// One word shifts out while the next waits in a single-entry holding buffer.
//
// state | meaning
// IDLE  | nothing shifting; x_out sits at IDLE_BIT
// SHIFT | a word is on x_out, one bit per clock
module seq_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned     CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);
    localparam int unsigned     OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic             hold_full_q;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] sh_q;
    logic [CW-1:0]    cnt_q;

    logic             accept;
    logic             at_last;
    logic [WIDTH-1:0] sh_next;

    assign accept  = din_valid && !hold_full_q;
    assign at_last = (cnt_q == LAST);
    // Shift toward the output end, zero-filling behind.
    assign sh_next = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            sh_q        <= '0;
            cnt_q       <= '0;
        end else begin
            if (accept) begin
                hold_q      <= din;
                hold_full_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (hold_full_q) begin
                        sh_q        <= hold_q;
                        cnt_q       <= '0;
                        hold_full_q <= 1'b0;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!at_last) begin
                        sh_q  <= sh_next;
                        cnt_q <= cnt_q + CW'(1);
                    end else if (hold_full_q) begin
                        // Reload on the last bit so consecutive words leave no idle gap.
                        sh_q        <= hold_q;
                        cnt_q       <= '0;
                        hold_full_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign din_ready  = !hold_full_q;
    assign x_valid    = (state_q == SHIFT);
    assign x_out      = (state_q == SHIFT) ? sh_q[OUT_IDX] : IDLE_BIT;
    assign frame_done = (state_q == SHIFT) && at_last;
    assign busy       = (state_q == SHIFT) || hold_full_q;

endmodule
